fib_seq_engine: RTL and testbench



---
 rtl/fib_seq_engine_if.sv | 51 +++++
 rtl/fib_seq_engine.sv | 161 ++++++++++++++++
 tb/tb_fib_seq_engine.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_engine_if.sv
// ---------------------------------------------------------------------------
// fib_seq_engine_if
// Request/response bundle between a requester and the fib_seq_engine.
//
// Parameters
//   NW       width of the Fibonacci index n
//   WIDTH    width of the result y
//
// Signals
//   start     requester -> engine   request strobe (taken only while busy=0)
//   n         requester -> engine   Fibonacci index, latched on accepted start
//   busy      engine -> requester   computation in progress
//   done      engine -> requester   one-cycle pulse, y/overflow valid
//   y         engine -> requester   result F(n) (wrapped or saturated)
//   overflow  engine -> requester   true F(n) did not fit in WIDTH bits
//
// Modports
//   master    requester side (testbench / host)
//   slave     engine side
// ---------------------------------------------------------------------------
interface fib_seq_engine_if #(
   parameter int NW    = 8,
   parameter int WIDTH = 32
);

   logic             start;
   logic [NW-1:0]    n;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             overflow;

   modport master (
      output start,
      output n,
      input  busy,
      input  done,
      input  y,
      input  overflow
   );

   modport slave (
      input  start,
      input  n,
      output busy,
      output done,
      output y,
      output overflow
   );

endinterface

// File: rtl/fib_seq_engine.sv
// ---------------------------------------------------------------------------
// fib_seq_engine
// Iterative Fibonacci generator: one addition per clock, F(0)=0, F(1)=1.
// A request (start + n) accepted in IDLE runs n add steps in CALC and then
// completes on the following edge, presenting F(n) on y with a one-cycle
// done pulse and an overflow flag that is set iff the true F(n) >= 2^WIDTH.
//
// Timing: start sampled at edge k -> busy high after edges k..k+n,
// result and done registered on edge k+n+1 (seen by a sampler at k+n+2).
// A start presented while done is high is accepted, so back-to-back
// requests run with no dead cycle. start while busy is ignored.
//
// Parameters
//   NW       width of index input n
//   WIDTH    width of result y and of the internal accumulators
//
// Ports
//   clock    system clock, all logic on posedge
//   reset    synchronous, active-high; aborts any in-flight request
//   bus      fib_seq_engine_if.slave (start, n, busy, done, y, overflow)
//
// Build option
//   FIB_SATURATE_EN  when defined, an overflowing result is reported as
//                    all ones instead of the value modulo 2^WIDTH. The
//                    overflow flag, latency and handshake are unchanged.
// ---------------------------------------------------------------------------
module fib_seq_engine #(
   parameter int NW    = 8,
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   fib_seq_engine_if.slave    bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [NW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             ova_q,   ova_d;
   logic             ovb_q,   ovb_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [WIDTH-1:0] y_q,     y_d;
   logic             ovf_q,   ovf_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] result;

   // One extra bit on the adder gives the carry that marks the first step
   // whose true sum no longer fits in WIDTH bits.
   assign sum = {1'b0, a_q} + {1'b0, b_q};

   // Value written to y on completion. a holds F(n) at that point; ova is
   // its sticky overflow (b already holds F(n+1) and must not be used).
`ifdef FIB_SATURATE_EN
   assign result = ova_q ? {WIDTH{1'b1}} : a_q;
`else
   assign result = a_q;
`endif

   // State and datapath register. Reset clears everything and drops any
   // request in flight without producing a result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ova_q   <= 1'b0;
         ovb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ova_q   <= ova_d;
         ovb_q   <= ovb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath logic. Everything holds by default and done
   // drops by default, so done can only be high for the single cycle that
   // follows a completing edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      ova_d   = ova_q;
      ovb_d   = ovb_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      y_d     = y_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d   = bus.n;
               a_d     = '0;
               b_d     = WIDTH'(1);
               ova_d   = 1'b0;
               ovb_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end

         CALC: begin
            if (cnt_q != '0) begin
               // Slide the window (a,b) = (F(i),F(i+1)) one index forward.
               // The overflow flags slide with it; once set they stay set
               // for the rest of the request.
               a_d   = b_q;
               b_d   = sum[WIDTH-1:0];
               ova_d = ovb_q;
               ovb_d = ovb_q | ova_q | sum[WIDTH];
               cnt_d = cnt_q - NW'(1);
            end else begin
               y_d     = result;
               ovf_d   = ova_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.y        = y_q;
   assign bus.overflow = ovf_q;

   // A completion always leaves the engine idle, and a completion can never
   // be immediately followed by another one.
   a_done_not_busy: assert property (@(posedge clock) disable iff (reset)
      done_q |-> !busy_q);
   a_done_single: assert property (@(posedge clock) disable iff (reset)
      done_q |=> !done_q);

endmodule

// File: tb/tb_fib_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_fib_seq_engine
// Self-checking bench for fib_seq_engine: reset state, a table of known
// Fibonacci values around the 32-bit overflow boundary, a back-to-back
// sweep, randomized requests against a reference model, and hand-written
// sequences for ignored starts and reset abort.
// Define FIB_SATURATE_EN for both bench and RTL to check the saturating
// build.
// ---------------------------------------------------------------------------
module tb_fib_seq_engine;

   localparam int NW    = 8;
   localparam int WIDTH = 32;
`ifdef FIB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   fib_seq_engine_if #(.NW(NW), .WIDTH(WIDTH)) bus ();

   fib_seq_engine #(.NW(NW), .WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int          n;
      logic [31:0] y_wrap;
      bit          ovf;
   } vec_t;

   vec_t vecs [10];

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: true Fibonacci value tracked with saturation well above
   // 2^32 to decide overflow, and a separate modulo-2^32 sequence for y.
   function automatic void refFib(input int nn, output logic [31:0] y_exp,
                                  output bit ovf_exp);
      longint unsigned cap = 64'd1 << 40;
      longint unsigned ta = 0, tb = 1, tt;
      logic [31:0] ma = 0, mb = 1, mt;
      for (int i = 0; i < nn; i++) begin
         tt = ta + tb;
         if (tt > cap) tt = cap;
         ta = tb;
         tb = tt;
         mt = ma + mb;
         ma = mb;
         mb = mt;
      end
      ovf_exp = (ta >= (64'd1 << 32));
      y_exp   = (ovf_exp && SAT) ? 32'hFFFF_FFFF : ma;
   endfunction

   // Present a request at the next falling edge; returns just after the
   // rising edge that samples it (edge k), with start already dropped.
   task automatic applyStimulus(input int nn);
      @(negedge clock);
      bus.start = 1'b1;
      bus.n     = NW'(nn);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   // Step cycles until done is seen (or the budget runs out), counting the
   // cycles after edge k and how many samples showed busy high.
   task automatic waitDone(input int limit, output int cycles,
                           output int busy_cnt);
      cycles   = 0;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && cycles < limit) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clock);
         #1;
         cycles++;
      end
   endtask

   // Full request: issue, wait, and check result, flag, latency and busy.
   task automatic runCheck(input int nn, input logic [31:0] y_exp,
                           input bit ovf_exp, input string tag);
      int cycles, busy_cnt;
      applyStimulus(nn);
      waitDone(nn + 10, cycles, busy_cnt);
      checkOutput($sformatf("%s_n%0d_done", tag, nn), {63'd0, bus.done}, 64'd1);
      checkOutput($sformatf("%s_n%0d_y", tag, nn), {32'd0, bus.y}, {32'd0, y_exp});
      checkOutput($sformatf("%s_n%0d_ovf", tag, nn), {63'd0, bus.overflow},
                  {63'd0, ovf_exp});
      checkOutput($sformatf("%s_n%0d_latency", tag, nn), cycles, nn + 1);
      checkOutput($sformatf("%s_n%0d_busy_cycles", tag, nn), busy_cnt, nn + 1);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] y_exp;
      bit          ovf_exp;
      int          cycles, busy_cnt, pulses, done_edge;
      logic [31:0] y_at_done;
      logic [31:0] y_hold;

      vecs[0] = '{0,  32'd0,          1'b0};
      vecs[1] = '{1,  32'd1,          1'b0};
      vecs[2] = '{2,  32'd1,          1'b0};
      vecs[3] = '{10, 32'd55,         1'b0};
      vecs[4] = '{20, 32'd6765,       1'b0};
      vecs[5] = '{46, 32'd1836311903, 1'b0};
      vecs[6] = '{47, 32'd2971215073, 1'b0};
      vecs[7] = '{48, 32'd512559680,  1'b1};
      vecs[8] = '{1,  32'd1,          1'b0};
      vecs[9] = '{0,  32'd0,          1'b0};

      // Reset state.
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.n     = '0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
      checkOutput("reset_y", {32'd0, bus.y}, 64'd0);
      checkOutput("reset_ovf", {63'd0, bus.overflow}, 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Table of known values, including the overflow boundary.
      for (int i = 0; i < 10; i++) begin
         y_exp = (vecs[i].ovf && SAT) ? 32'hFFFF_FFFF : vecs[i].y_wrap;
         runCheck(vecs[i].n, y_exp, vecs[i].ovf, "table");
         repeat (2) @(posedge clock);
         #1;
      end

      // Result must hold while idle.
      runCheck(10, 32'd55, 1'b0, "hold");
      y_hold = bus.y;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("hold_y", {32'd0, bus.y}, {32'd0, y_hold});
      checkOutput("hold_done_low", {63'd0, bus.done}, 64'd0);

      // Back-to-back sweep: each next start issued in the done cycle.
      for (int nn = 0; nn <= 46; nn++) begin
         refFib(nn, y_exp, ovf_exp);
         runCheck(nn, y_exp, ovf_exp, "sweep");
      end

      // Randomized requests with random idle gaps.
      for (int r = 0; r < 25; r++) begin
         int nn;
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
         nn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 60));
         refFib(nn, y_exp, ovf_exp);
         runCheck(nn, y_exp, ovf_exp, "rand");
      end

      // start pulsed with n=5 while busy on n=20: must be ignored.
      repeat (2) @(posedge clock);
      #1;
      applyStimulus(20);
      pulses    = 0;
      done_edge = -1;
      y_at_done = '0;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clock);
         bus.start = (e == 3 || e == 10);
         bus.n     = NW'(5);
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) begin
            pulses++;
            if (done_edge < 0) begin
               done_edge = e;
               y_at_done = bus.y;
            end
         end
      end
      bus.start = 1'b0;
      checkOutput("ignore_pulses", pulses, 1);
      checkOutput("ignore_done_edge", done_edge, 21);
      checkOutput("ignore_y", {32'd0, y_at_done}, 64'd6765);

      // Reset abort of an n=40 request at edge k+15.
      applyStimulus(40);
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("abort_done", {63'd0, bus.done}, 64'd0);
      checkOutput("abort_y", {32'd0, bus.y}, 64'd0);
      checkOutput("abort_ovf", {63'd0, bus.overflow}, 64'd0);
      @(negedge clock);
      reset  = 1'b0;
      pulses = 0;
      busy_cnt = 0;
      for (int e = 0; e < 50; e++) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) pulses++;
         if (bus.busy === 1'b1) busy_cnt++;
      end
      checkOutput("abort_no_done", pulses, 0);
      checkOutput("abort_no_busy", busy_cnt, 0);
      runCheck(12, 32'd144, 1'b0, "after_abort");

      // Done pulse lasts exactly one cycle.
      @(posedge clock);
      #1;
      checkOutput("done_one_cycle", {63'd0, bus.done}, 64'd0);

      // Timeout path for completeness of waitDone usage on a long request.
      refFib(255, y_exp, ovf_exp);
      applyStimulus(255);
      waitDone(300, cycles, busy_cnt);
      checkOutput("n255_done", {63'd0, bus.done}, 64'd1);
      checkOutput("n255_y", {32'd0, bus.y}, {32'd0, y_exp});
      checkOutput("n255_ovf", {63'd0, bus.overflow}, {63'd0, ovf_exp});
      checkOutput("n255_latency", cycles, 256);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
